// File: rtl/clk_rst_pkg.sv
// Shared types and widths for the clock/reset sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package clk_rst_pkg;

  // Sequencer states; the encoding is visible on the debug state port.
  typedef enum logic [2:0] {
    WAIT_LOCK = 3'd0,
    QUALIFY   = 3'd1,
    RELEASE   = 3'd2,
    RUN       = 3'd3
  } state_e;

  localparam int CE_W   = 16;  // clock-enable divider width
  localparam int LOSS_W = 8;   // saturating lock-loss counter width

endpackage

// File: rtl/clk_rst_seq_sync2.sv
// Two-flop synchroniser for a single asynchronous level (PLL lock).
// Latency: 2 clk edges from d to q.
// Backpressure: none; free-running every cycle.
// Ports: clk - destination clock; rst_n - async active-low reset (q -> 0);
//        d - asynchronous input; q - synchronised output.
module sync2 (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta_q, meta_d;
  logic sync_q, sync_d;

  always_comb begin
    meta_d = d;
    sync_d = meta_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/clk_rst_seq.sv
// Qualifies PLL lock, releases domain resets in staggered order, makes CE ticks.
// Latency: lock loss drops all resets 3 edges after pll_locked falls; all outputs registered.
// Backpressure: none; requests are single-cycle pulses, outputs are free-running.
// Ports: clk, resetn (async active-low); pll_locked (raw, async); sw_rst_req and
//        clr_status (1-cycle pulses); rst_n[N_RST] domain resets (bit 0 first);
//        ready (high in RUN); ce[N_CE] strobes; lock_lost/loss_cnt status; state debug.
module clk_rst_seq
  import clk_rst_pkg::*;
#(
  parameter int                     N_RST       = 3,
  parameter int                     LOCK_CYCLES = 1024,
  parameter int                     STAGE_GAP   = 16,
  parameter int                     N_CE        = 2,
  parameter logic [N_CE*CE_W-1:0]   CE_DIV      = {16'd30000, 16'd30}
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              pll_locked,
  input  logic              sw_rst_req,
  input  logic              clr_status,
  output logic [N_RST-1:0]  rst_n,
  output logic              ready,
  output logic [N_CE-1:0]   ce,
  output logic              lock_lost,
  output logic [LOSS_W-1:0] loss_cnt,
  output logic [2:0]        state
);

  localparam int LC_W  = $clog2(LOCK_CYCLES + 1);
  localparam int GAP_W = $clog2(STAGE_GAP + 1);

  localparam logic [LC_W-1:0]   LOCK_LAST = LC_W'(LOCK_CYCLES);
  localparam logic [LC_W-1:0]   LC_ONE    = LC_W'(1);
  localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'(STAGE_GAP);
  localparam logic [GAP_W-1:0]  GAP_ONE   = GAP_W'(1);
  localparam logic [LOSS_W-1:0] LOSS_ONE  = LOSS_W'(1);
  localparam logic [CE_W-1:0]   CE_ONE    = CE_W'(1);

  logic lk;

  sync2 u_lock_sync (
    .clk   (clk),
    .rst_n (resetn),
    .d     (pll_locked),
    .q     (lk)
  );

  state_e              state_q, state_d;
  logic [LC_W-1:0]     lock_cnt_q, lock_cnt_d;
  logic [GAP_W-1:0]    gap_cnt_q, gap_cnt_d;
  logic [N_RST-1:0]    rst_n_q, rst_n_d;
  logic                ready_q, ready_d;
  logic                lock_lost_q, lock_lost_d;
  logic [LOSS_W-1:0]   loss_cnt_q, loss_cnt_d;
  logic                loss_evt;
  logic                enter_rel;

  // Sequencer next-state. The cycle that moves WAIT_LOCK -> QUALIFY already
  // counts as the first qualified cycle, so rst_n[0] rises exactly
  // LOCK_CYCLES edges after the synchronised lock first reads high.
  always_comb begin
    state_d    = state_q;
    lock_cnt_d = lock_cnt_q;
    gap_cnt_d  = gap_cnt_q;
    rst_n_d    = rst_n_q;
    ready_d    = ready_q;
    loss_evt   = 1'b0;
    enter_rel  = 1'b0;

    case (state_q)
      WAIT_LOCK: begin
        lock_cnt_d = '0;
        gap_cnt_d  = '0;
        rst_n_d    = '0;
        ready_d    = 1'b0;
        if (lk) begin
          if (LOCK_LAST == LC_ONE) begin
            enter_rel = 1'b1;
          end else begin
            state_d    = QUALIFY;
            lock_cnt_d = LC_ONE;
          end
        end
      end

      QUALIFY: begin
        rst_n_d = '0;
        ready_d = 1'b0;
        if (!lk) begin
          // A dropout before release is just an unqualified lock, not a loss.
          state_d    = WAIT_LOCK;
          lock_cnt_d = '0;
        end else if (lock_cnt_q + LC_ONE == LOCK_LAST) begin
          enter_rel = 1'b1;
        end else begin
          lock_cnt_d = lock_cnt_q + LC_ONE;
        end
      end

      RELEASE, RUN: begin
        if (!lk || sw_rst_req) begin
          // Lock loss wins over a simultaneous software request.
          loss_evt   = !lk;
          state_d    = WAIT_LOCK;
          rst_n_d    = '0;
          ready_d    = 1'b0;
          gap_cnt_d  = '0;
          lock_cnt_d = '0;
        end else if (state_q == RELEASE) begin
          gap_cnt_d = gap_cnt_q + GAP_ONE;
          if (gap_cnt_q + GAP_ONE == GAP_LAST) begin
            gap_cnt_d  = '0;
            // Released bits walk upward; a released bit never re-asserts.
            rst_n_d[0] = 1'b1;
            for (int k = 1; k < N_RST; k++) begin
              rst_n_d[k] = rst_n_q[k-1];
            end
            if (rst_n_d[N_RST-1]) begin
              state_d = RUN;
              ready_d = 1'b1;
            end
          end
        end
      end

      default: begin
        state_d    = WAIT_LOCK;
        lock_cnt_d = '0;
        gap_cnt_d  = '0;
        rst_n_d    = '0;
        ready_d    = 1'b0;
      end
    endcase

    if (enter_rel) begin
      lock_cnt_d = '0;
      gap_cnt_d  = '0;
      rst_n_d    = '0;
      rst_n_d[0] = 1'b1;
      // A single domain completes release on the entry edge itself.
      if (N_RST == 1) begin
        state_d = RUN;
        ready_d = 1'b1;
      end else begin
        state_d = RELEASE;
      end
    end
  end

  // Sticky status; a clear that coincides with a loss leaves exactly that loss.
  always_comb begin
    lock_lost_d = lock_lost_q | loss_evt;
    loss_cnt_d  = loss_cnt_q;
    if (clr_status) begin
      lock_lost_d = loss_evt;
      loss_cnt_d  = loss_evt ? LOSS_ONE : '0;
    end else if (loss_evt && (loss_cnt_q != '1)) begin
      loss_cnt_d = loss_cnt_q + LOSS_ONE;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= WAIT_LOCK;
      lock_cnt_q  <= '0;
      gap_cnt_q   <= '0;
      rst_n_q     <= '0;
      ready_q     <= 1'b0;
      lock_lost_q <= 1'b0;
      loss_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      lock_cnt_q  <= lock_cnt_d;
      gap_cnt_q   <= gap_cnt_d;
      rst_n_q     <= rst_n_d;
      ready_q     <= ready_d;
      lock_lost_q <= lock_lost_d;
      loss_cnt_q  <= loss_cnt_d;
    end
  end

  // Clock-enable dividers. Counting starts the cycle after ready rises, and the
  // strobe is gated by ready_d so it drops on the same edge as ready.
  for (genvar i = 0; i < N_CE; i++) begin : g_ce
    localparam logic [CE_W-1:0] DIV = CE_DIV[CE_W*i +: CE_W];

    logic [CE_W-1:0] cnt_q, cnt_d, cnt_inc;
    logic            ce_q, ce_d;

    always_comb begin
      cnt_inc = cnt_q + CE_ONE;
      cnt_d   = '0;
      ce_d    = 1'b0;
      if (ready_q && ready_d) begin
        if (cnt_inc == DIV) begin
          ce_d = 1'b1;
        end else begin
          cnt_d = cnt_inc;
        end
      end
    end

    always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
        cnt_q <= '0;
        ce_q  <= 1'b0;
      end else begin
        cnt_q <= cnt_d;
        ce_q  <= ce_d;
      end
    end

    assign ce[i] = ce_q;
  end

  assign rst_n     = rst_n_q;
  assign ready     = ready_q;
  assign lock_lost = lock_lost_q;
  assign loss_cnt  = loss_cnt_q;
  assign state     = state_q;

endmodule
